// File: rtl/wb_host_pkg.sv
// Shared types and default sizing for the Wishbone host master.
package wb_host_pkg;

  // Default bus geometry and ack timeout.
  localparam int unsigned DefaultAw      = 32;
  localparam int unsigned DefaultDw      = 32;
  localparam int unsigned DefaultTimeout = 255;

  // Transaction FSM: one outstanding command at a time.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_host_timeout.sv
// Ack timeout counter: counts bus cycles without ack and flags the last allowed one.
module wb_host_timeout
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tc fires in the cycle whose increment would reach TIMEOUT; en already excludes ack.
  assign tc = en && (cnt_q == LastCnt);

  // Next count: clear on entry to the bus phase, count ack-less bus cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_host_master.sv
// Converts a valid/ready command into a single classic Wishbone cycle and
// returns the result (read data or timeout) on a valid/ready response channel.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic            clk_i,
  input  logic            rst_n,
  // Command channel
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  // Response channel
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  // Wishbone initiator
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  state_e state_q, state_d;

  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;

  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;

  logic cmd_fire;
  logic rsp_fire;
  logic in_bus;
  logic bus_ack;
  logic to_en;
  logic to_tc;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign in_bus   = (state_q == StBus);
  // Acks outside the bus phase (late acks after a timeout) are dropped here.
  assign bus_ack  = in_bus && wb_ack_i;
  assign to_en    = in_bus && !wb_ack_i;

  wb_host_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr   (cmd_fire),
    .en    (to_en),
    .tc    (to_tc)
  );

  // State register; reset aborts any cycle in flight without a response.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes priority over the terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_fire) state_d = StBus;
      StBus: begin
        if (wb_ack_i || to_tc) state_d = StResp;
      end
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded handshake and bus-control outputs.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wb_cyc_o  = 1'b0;
    unique case (state_q)
      // Gate with rst_n so cmd_ready stays low for the whole reset pulse.
      StIdle:  cmd_ready = rst_n;
      StBus:   wb_cyc_o  = 1'b1;
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign wb_stb_o = wb_cyc_o;

  // Command capture; held unchanged until the next accepted command.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (cmd_fire) begin
      we_q  <= cmd_we;
      adr_q <= cmd_adr;
      dat_q <= cmd_dat;
      sel_q <= cmd_sel;
    end
  end

  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

  // Response payload: read data on ack, zero data with err on timeout.
  always_comb begin
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    if (bus_ack) begin
      rsp_dat_d = we_q ? '0 : wb_dat_i;
      rsp_err_d = 1'b0;
    end else if (to_tc) begin
      rsp_dat_d = '0;
      rsp_err_d = 1'b1;
    end else if (rsp_fire) begin
      rsp_dat_d = '0;
      rsp_err_d = 1'b0;
    end
  end

  // Response payload register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_dat = rsp_dat_q;
  assign rsp_err = rsp_err_q;

  // Protocol invariants.
  a_stb_eq_cyc : assert property (@(posedge clk_i) disable iff (!rst_n)
    wb_stb_o == wb_cyc_o);

  a_bus_stable : assert property (@(posedge clk_i) disable iff (!rst_n)
    (wb_cyc_o && $past(wb_cyc_o)) |-> $stable({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}));

  a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable({rsp_dat, rsp_err})));

  a_ready_idle : assert property (@(posedge clk_i) disable iff (!rst_n)
    cmd_ready |-> (state_q == StIdle));

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench: two instances (TIMEOUT=8 and TIMEOUT=4) share stimulus;
// table-driven transactions plus hand-written reset and late-ack sequences.
module tb_wb_host_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_ready;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  logic        cmd_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we;
  logic [31:0] rsp_dat, wb_adr, wb_dat;
  logic [3:0]  wb_sel;

  logic        t4_cmd_ready, t4_rsp_valid, t4_rsp_err, t4_wb_cyc, t4_wb_stb, t4_wb_we;
  logic [31:0] t4_rsp_dat, t4_wb_adr, t4_wb_dat;
  logic [3:0]  t4_wb_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_wait;  // ack in bus cycle ack_wait+1; negative = never
    logic [31:0] rdat;
    int          hold;      // cycles rsp_ready stays low
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic        exp4_err;
    logic [31:0] exp4_dat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        err4;
    logic [31:0] dat4;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];

  wb_host_master #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut8 (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_we_o   (wb_we),
    .wb_adr_o  (wb_adr),
    .wb_dat_o  (wb_dat),
    .wb_sel_o  (wb_sel),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  wb_host_master #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut4 (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (t4_cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (t4_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (t4_rsp_dat),
    .rsp_err   (t4_rsp_err),
    .wb_cyc_o  (t4_wb_cyc),
    .wb_stb_o  (t4_wb_stb),
    .wb_we_o   (t4_wb_we),
    .wb_adr_o  (t4_wb_adr),
    .wb_dat_o  (t4_wb_dat),
    .wb_sel_o  (t4_wb_sel),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int ack_wait,
                              input logic [31:0] rdat, input int hold, input int exp_cyc,
                              input logic exp_err, input logic [31:0] exp_dat,
                              input logic exp4_err, input logic [31:0] exp4_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ack_wait = ack_wait;
    v.rdat = rdat; v.hold = hold; v.exp_cyc = exp_cyc; v.exp_err = exp_err;
    v.exp_dat = exp_dat; v.exp4_err = exp4_err; v.exp4_dat = exp4_dat;
    return v;
  endfunction

  // One full transaction: command, bus phase with modelled responder, response.
  task automatic run_vec(input vec_t v, input bit late_ack);
    int   ncyc;
    int   ncyc4;
    int   exp4_cyc;
    bit   done;
    exp_t e;
    ncyc  = 0;
    ncyc4 = 0;
    done  = 0;
    exp4_cyc = (v.exp_cyc > 4) ? 4 : v.exp_cyc;

    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    wb_dat_i  = v.rdat; wb_ack_i = 1'b0;
    sb.push_back('{err: v.exp_err, dat: v.exp_dat, err4: v.exp4_err, dat4: v.exp4_dat});
    @(negedge clk);
    // Scramble the command bus so held values must come from the DUT registers.
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = ~v.adr; cmd_dat = ~v.dat; cmd_sel = ~v.sel;

    for (int c = 0; c < 300 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (t4_wb_cyc) ncyc4++;
      if (wb_cyc) begin
        ncyc++;
        chk("wb_stb", wb_stb, 1'b1);
        chk("wb_we", wb_we, v.we);
        chk("wb_adr", wb_adr, v.adr);
        chk("wb_dat", wb_dat, v.dat);
        chk("wb_sel", wb_sel, v.sel);
        wb_ack_i = (v.ack_wait >= 0) && (ncyc == v.ack_wait + 1);
      end else begin
        wb_ack_i = 1'b0;
        done = 1;
      end
    end
    chk("bus_phase_ended", done, 1'b1);
    chk("cyc_len", ncyc, v.exp_cyc);
    chk("cyc_len_t4", ncyc4, exp4_cyc);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_valid_t4", t4_rsp_valid, 1'b1);
    chk("cmd_ready_resp", cmd_ready, 1'b0);

    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      chk("rsp_dat", rsp_dat, e.dat);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_dat_t4", t4_rsp_dat, e.dat4);
      chk("rsp_err_t4", t4_rsp_err, e.err4);
    end

    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      wb_ack_i  = late_ack && (h == 1);
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_dat", rsp_dat, e.dat);
      chk("hold_rsp_err", rsp_err, e.err);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      chk("hold_cyc", wb_cyc, 1'b0);
      chk("hold_cyc_t4", t4_wb_cyc, 1'b0);
    end

    cmd_valid = 1'b0;
    wb_ack_i  = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_cmd_ready", cmd_ready, 1'b1);
    chk("post_cmd_ready_t4", t4_cmd_ready, 1'b1);
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_cyc", wb_cyc, 1'b0);
  endtask

  initial begin
    //        we    adr           dat           sel   wait rdat          hold cyc err dat
    tbl[0] = mk(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'hDEAD_BEEF, 0, 3,
                1'b0, 32'h0, 1'b0, 32'h0);
    tbl[1] = mk(1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 0, 32'hCAFE_F00D, 0, 1,
                1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
    tbl[2] = mk(1'b0, 32'h3000_0020, 32'h0000_0000, 4'h3, 1, 32'h1234_5678, 5, 2,
                1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678);
    tbl[3] = mk(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h1, 1, 32'h5555_AAAA, 1, 2,
                1'b0, 32'h0, 1'b0, 32'h0);
    // Ack in cycle 6: TIMEOUT=8 instance completes, TIMEOUT=4 instance times out.
    tbl[4] = mk(1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC, 5, 32'h0BAD_F00D, 0, 6,
                1'b0, 32'h0BAD_F00D, 1'b1, 32'h0);
    // No ack: both time out; a late ack arrives while the response is held.
    tbl[5] = mk(1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF, -1, 32'h7777_7777, 3, 8,
                1'b1, 32'h0, 1'b1, 32'h0);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;

    #3;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_cyc", wb_cyc, 1'b0);
    chk("reset_stb", wb_stb, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_dat", rsp_dat, 32'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_wb_adr", wb_adr, 32'h0);
    chk("reset_cmd_ready_t4", t4_cmd_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], i == 5);
    end

    // Reset pulsed mid-bus: cycle drops at once and no response follows.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    wb_dat_i  = 32'h1111_1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_mid_cyc_before", wb_cyc, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", wb_cyc, 1'b0);
    chk("rst_mid_stb", wb_stb, 1'b0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mid_cyc_t4", t4_wb_cyc, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wb_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_rsp_valid", rsp_valid, 1'b0);
      chk("after_rst_cyc", wb_cyc, 1'b0);
      chk("after_rst_cmd_ready", cmd_ready, 1'b1);
    end
    wb_ack_i = 1'b0;
    chk("after_rst_sb_empty", sb.size(), 0);

    run_vec(tbl[1], 1'b0);

    // Ack in the TIMEOUT=4 instance's terminal-count cycle: ack must win.
    run_vec(mk(1'b0, 32'h3000_0050, 32'h0, 4'hF, 3, 32'h600D_CAFE, 0, 4,
               1'b0, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE), 1'b0);

    // Back-to-back write after the corner cases.
    run_vec(tbl[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
